// File: rtl/comm_pkg.sv
// Shared types and constants for the transmit scheduler: message type codes,
// frame field widths, FSM states and the fixed arbitration order.
package comm_pkg;

    localparam int FRAME_W    = 24;
    localparam int TYPE_W     = 4;
    localparam int PAYLOAD_W  = 20;
    localparam int NUM_TYPES  = 7;
    localparam int BALL_PL_W  = 18;
    localparam int MISS_PL_W  = 11;

    typedef enum logic [TYPE_W-1:0] {
        MSG_NONE          = 4'd0,
        MSG_BALL          = 4'd1,
        MSG_MISS          = 4'd2,
        MSG_NEW_GAME      = 4'd3,
        MSG_NEW_GAME_ACK  = 4'd4,
        MSG_ARE_YOU_THERE = 4'd5,
        MSG_I_AM_HERE     = 4'd6,
        MSG_I_LOST        = 4'd7
    } msg_type_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_HOLD,
        ST_WAIT_SENT,
        ST_WAIT_ACK
    } tx_state_t;

    // Pending-vector bit index to message type; bit 6 is the highest priority.
    function automatic msg_type_t prio_type(input logic [2:0] idx);
        case (idx)
            3'd6:    return MSG_NEW_GAME_ACK;
            3'd5:    return MSG_NEW_GAME;
            3'd4:    return MSG_MISS;
            3'd3:    return MSG_I_LOST;
            3'd2:    return MSG_BALL;
            3'd1:    return MSG_ARE_YOU_THERE;
            3'd0:    return MSG_I_AM_HERE;
            default: return MSG_NONE;
        endcase
    endfunction

    function automatic logic [2:0] top_index(input logic [NUM_TYPES-1:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < NUM_TYPES; i++) begin
            if (vec[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/comm_tx_scheduler_packer.sv
// Combinational frame builder: type code in [23:20], payload LSB-aligned and
// zero-padded in [19:0].
module comm_msg_packer
    import comm_pkg::*;
(
    input  msg_type_t            msg_type,
    input  logic [BALL_PL_W-1:0] ball_payload,
    input  logic [MISS_PL_W-1:0] miss_payload,
    input  logic                 new_game_payload,
    output logic [FRAME_W-1:0]   frame
);

    logic [PAYLOAD_W-1:0] payload;

    always_comb begin
        payload = '0;
        case (msg_type)
            MSG_BALL:     payload = PAYLOAD_W'(ball_payload);
            MSG_MISS:     payload = PAYLOAD_W'(miss_payload);
            MSG_NEW_GAME: payload = PAYLOAD_W'(new_game_payload);
            default:      payload = '0;
        endcase
        frame = {msg_type, payload};
    end

endmodule

// File: rtl/comm_tx_scheduler.sv
// Priority scheduler feeding CommunicationSender. Build option COMM_TX_RETRY_EN
// adds ack wait, timeout retransmission and the sticky link_lost flag.
module comm_tx_scheduler
    import comm_pkg::*;
#(
    parameter int ACK_TIMEOUT = 500_000,
    parameter int MAX_RETRIES = 3
) (
    input  logic                 CLOCK_50,
    input  logic                 reset,
    input  logic                 ball_message_tx,
    input  logic                 miss_message_tx,
    input  logic                 new_game_message_tx,
    input  logic                 new_game_ack_message_tx,
    input  logic                 are_you_there_tx,
    input  logic                 I_am_here_tx,
    input  logic                 I_lost_tx,
    input  logic [8:0]           ball_y_tx,
    input  logic [3:0]           velocity_x_tx,
    input  logic [3:0]           velocity_y_tx,
    input  logic                 sign_y_tx,
    input  logic [4:0]           my_score_tx,
    input  logic [4:0]           your_score_tx,
    input  logic                 you_should_serve_tx,
    input  logic                 you_serve_first_tx,
    input  logic                 message_sent,
    input  logic                 message_acked,
    output logic                 send_new_message,
    output logic [FRAME_W-1:0]   message_data_out,
    output logic                 busy,
    output logic [NUM_TYPES-1:0] pending,
    output logic                 link_lost
);

    tx_state_t              state, state_n;
    logic [NUM_TYPES-1:0]   req, pending_q, pending_n;
    logic [BALL_PL_W-1:0]   ball_pl;
    logic [MISS_PL_W-1:0]   miss_pl;
    logic                   new_game_pl;
    logic [FRAME_W-1:0]     frame_q, packed_frame;
    logic                   send_q, busy_q, hold_cnt;
    logic                   launch;
    logic [2:0]             win_idx;
    msg_type_t              win_type;

    assign req = {new_game_ack_message_tx, new_game_message_tx, miss_message_tx,
                  I_lost_tx, ball_message_tx, are_you_there_tx, I_am_here_tx};

    assign win_idx  = top_index(pending_q);
    assign win_type = prio_type(win_idx);

    comm_msg_packer u_packer (
        .msg_type         (win_type),
        .ball_payload     (ball_pl),
        .miss_payload     (miss_pl),
        .new_game_payload (new_game_pl),
        .frame            (packed_frame)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            ball_pl     <= '0;
            miss_pl     <= '0;
            new_game_pl <= 1'b0;
        end else begin
            if (ball_message_tx)
                ball_pl <= {ball_y_tx, velocity_x_tx, velocity_y_tx, sign_y_tx};
            if (miss_message_tx)
                miss_pl <= {my_score_tx, your_score_tx, you_should_serve_tx};
            if (new_game_message_tx)
                new_game_pl <= you_serve_first_tx;
        end
    end

`ifdef COMM_TX_RETRY_EN
    localparam int TIMER_W = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(ACK_TIMEOUT);
    localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

    logic [TIMER_W-1:0] timer;
    logic [RETRY_W-1:0] retries;
    logic               start_ack, retry, drop, link_lost_q;
`else
    logic unused_cfg;
    assign unused_cfg = message_acked ^ (ACK_TIMEOUT > 0) ^ (MAX_RETRIES > 0);
`endif

    always_comb begin
        state_n = state;
        launch  = 1'b0;
`ifdef COMM_TX_RETRY_EN
        start_ack = 1'b0;
        retry     = 1'b0;
        drop      = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                if (|pending_q && message_sent) begin
                    launch  = 1'b1;
                    state_n = ST_SEND;
                end
            end
            ST_SEND: state_n = ST_HOLD;
            ST_HOLD: begin
                if (hold_cnt) state_n = ST_WAIT_SENT;
            end
            ST_WAIT_SENT: begin
                if (message_sent) begin
`ifdef COMM_TX_RETRY_EN
                    state_n   = ST_WAIT_ACK;
                    start_ack = 1'b1;
`else
                    state_n = ST_IDLE;
`endif
                end
            end
`ifdef COMM_TX_RETRY_EN
            ST_WAIT_ACK: begin
                if (message_acked) begin
                    state_n = ST_IDLE;
                end else if (timer == '0) begin
                    if (retries < RETRY_MAX) begin
                        retry   = 1'b1;
                        state_n = ST_SEND;
                    end else begin
                        drop    = 1'b1;
                        state_n = ST_IDLE;
                    end
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase
    end

    // A request landing on the same edge as its own launch stays pending.
    always_comb begin
        pending_n = pending_q;
        if (launch) pending_n[win_idx] = 1'b0;
        pending_n = pending_n | req;
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pending_q <= '0;
            frame_q   <= '0;
            send_q    <= 1'b0;
            busy_q    <= 1'b0;
            hold_cnt  <= 1'b0;
        end else begin
            state     <= state_n;
            pending_q <= pending_n;
            if (launch) frame_q <= packed_frame;
            send_q    <= (state_n == ST_SEND);
            busy_q    <= (state_n != ST_IDLE);
            hold_cnt  <= (state == ST_HOLD) ? ~hold_cnt : 1'b0;
        end
    end

`ifdef COMM_TX_RETRY_EN
    // Retry count is cleared only on a fresh launch so it survives the
    // SEND/HOLD/WAIT_SENT pass of each retransmission.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timer       <= '0;
            retries     <= '0;
            link_lost_q <= 1'b0;
        end else begin
            if (start_ack)
                timer <= TIMER_LOAD;
            else if (state == ST_WAIT_ACK && timer != '0)
                timer <= timer - 1'b1;

            if (launch)
                retries <= '0;
            else if (retry)
                retries <= retries + 1'b1;

            if (drop)
                link_lost_q <= 1'b1;
            else if (new_game_message_tx)
                link_lost_q <= 1'b0;
        end
    end

    assign link_lost = link_lost_q;
`else
    assign link_lost = 1'b0;
`endif

    assign send_new_message = send_q;
    assign message_data_out = frame_q;
    assign busy             = busy_q;
    assign pending          = pending_q;

endmodule

// File: tb/tb_comm_tx_scheduler.sv
// Directed bench for comm_tx_scheduler with a simple sender model; the retry
// scenarios run only when COMM_TX_RETRY_EN is defined.
module tb_comm_tx_scheduler;

    logic        CLOCK_50 = 1'b0;
    logic        reset;
    logic        ball_message_tx, miss_message_tx, new_game_message_tx;
    logic        new_game_ack_message_tx, are_you_there_tx, I_am_here_tx, I_lost_tx;
    logic [8:0]  ball_y_tx;
    logic [3:0]  velocity_x_tx, velocity_y_tx;
    logic        sign_y_tx;
    logic [4:0]  my_score_tx, your_score_tx;
    logic        you_should_serve_tx, you_serve_first_tx;
    logic        message_sent, message_acked;
    logic        send_new_message;
    logic [23:0] message_data_out;
    logic        busy;
    logic [6:0]  pending;
    logic        link_lost;

    int          checks = 0;
    int          errors = 0;
    int          sender_cnt = 0;
    int          base;
    logic [23:0] frames[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    comm_tx_scheduler #(.ACK_TIMEOUT(10), .MAX_RETRIES(3)) dut (
        .CLOCK_50                (CLOCK_50),
        .reset                   (reset),
        .ball_message_tx         (ball_message_tx),
        .miss_message_tx         (miss_message_tx),
        .new_game_message_tx     (new_game_message_tx),
        .new_game_ack_message_tx (new_game_ack_message_tx),
        .are_you_there_tx        (are_you_there_tx),
        .I_am_here_tx            (I_am_here_tx),
        .I_lost_tx               (I_lost_tx),
        .ball_y_tx               (ball_y_tx),
        .velocity_x_tx           (velocity_x_tx),
        .velocity_y_tx           (velocity_y_tx),
        .sign_y_tx               (sign_y_tx),
        .my_score_tx             (my_score_tx),
        .your_score_tx           (your_score_tx),
        .you_should_serve_tx     (you_should_serve_tx),
        .you_serve_first_tx      (you_serve_first_tx),
        .message_sent            (message_sent),
        .message_acked           (message_acked),
        .send_new_message        (send_new_message),
        .message_data_out        (message_data_out),
        .busy                    (busy),
        .pending                 (pending),
        .link_lost               (link_lost)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        #2;
    endtask

    // mask order matches pending: {ng_ack, ng, miss, lost, ball, ayt, iah}
    task automatic pulse(input logic [6:0] mask);
        {new_game_ack_message_tx, new_game_message_tx, miss_message_tx, I_lost_tx,
         ball_message_tx, are_you_there_tx, I_am_here_tx} = mask;
        tick();
        {new_game_ack_message_tx, new_game_message_tx, miss_message_tx, I_lost_tx,
         ball_message_tx, are_you_there_tx, I_am_here_tx} = 7'b0;
    endtask

    task automatic wait_frames(input int n, input string tag);
        int k = 0;
        while (frames.size() < n && k < 300) begin
            tick();
            k++;
        end
        check_val(tag, 32'(frames.size()), 32'(n));
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while (busy && k < 400) begin
            tick();
            k++;
        end
        check_val(tag, 32'(busy), 32'd0);
    endtask

    task automatic wait_ready(input string tag);
        int k = 0;
        while (!message_sent && k < 100) begin
            tick();
            k++;
        end
        check_val(tag, 32'(message_sent), 32'd1);
    endtask

    task automatic ack_current(input string tag);
        wait_ready(tag);
        tick();
        message_acked = 1'b1;
        tick();
        message_acked = 1'b0;
    endtask

    task automatic complete(input string tag);
`ifdef COMM_TX_RETRY_EN
        ack_current({tag, "_ack"});
`endif
        wait_idle({tag, "_idle"});
    endtask

    // Sender model: drops ready on each pulse and restores it 6 cycles later.
    initial begin
        message_sent = 1'b1;
        forever begin
            @(posedge CLOCK_50);
            #1;
            if (sender_cnt > 0) begin
                sender_cnt--;
                if (sender_cnt == 0) message_sent = 1'b1;
            end
            if (send_new_message === 1'b1) begin
                frames.push_back(message_data_out);
                message_sent = 1'b0;
                sender_cnt   = 6;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        message_acked = 1'b0;
        {new_game_ack_message_tx, new_game_message_tx, miss_message_tx, I_lost_tx,
         ball_message_tx, are_you_there_tx, I_am_here_tx} = 7'b0;
        ball_y_tx = 9'h1A5; velocity_x_tx = 4'd3; velocity_y_tx = 4'd5; sign_y_tx = 1'b1;
        my_score_tx = 5'd7; your_score_tx = 5'd2; you_should_serve_tx = 1'b1;
        you_serve_first_tx = 1'b1;
        repeat (3) tick();
        check_val("rst_send", 32'(send_new_message), 32'd0);
        check_val("rst_data", 32'(message_data_out), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        check_val("rst_pending", 32'(pending), 32'd0);
        check_val("rst_link_lost", 32'(link_lost), 32'd0);
        reset = 1'b0;
        tick();

        // Ball send latency and frame packing
        pulse(7'b0000100);
        check_val("ball_pending", 32'(pending), 32'h04);
        check_val("ball_send_n1", 32'(send_new_message), 32'd0);
        tick();
        check_val("ball_send_n2", 32'(send_new_message), 32'd1);
        check_val("ball_frame", 32'(message_data_out), 32'h134A6B);
        check_val("ball_busy", 32'(busy), 32'd1);
        check_val("ball_pending_clr", 32'(pending), 32'h00);
        tick();
        check_val("ball_send_one", 32'(send_new_message), 32'd0);
        check_val("ball_frame_hold", 32'(message_data_out), 32'h134A6B);
        complete("ball");

        // MISS and BALL together: MISS wins, BALL waits for retirement
        base = frames.size();
        pulse(7'b0010100);
        wait_frames(base + 1, "sim_first");
        check_val("sim_miss_frame", 32'(frames[base]), 32'h2001C5);
        check_val("sim_ball_pending", 32'(pending), 32'h04);
`ifdef COMM_TX_RETRY_EN
        wait_ready("sim_ready");
        repeat (5) tick();
        check_val("sim_ball_held", 32'(frames.size()), 32'(base + 1));
        message_acked = 1'b1;
        tick();
        message_acked = 1'b0;
`endif
        wait_frames(base + 2, "sim_second");
        check_val("sim_ball_frame", 32'(frames[base+1]), 32'h134A6B);
        complete("sim_ball");

        // Two BALL requests during NEW_GAME flight collapse to one frame
        base = frames.size();
        pulse(7'b0100000);
        wait_frames(base + 1, "ovr_ng");
        check_val("ovr_ng_frame", 32'(frames[base]), 32'h300001);
        ball_y_tx = 9'h0FF; velocity_x_tx = 4'd1; velocity_y_tx = 4'd2; sign_y_tx = 1'b0;
        pulse(7'b0000100);
        ball_y_tx = 9'h003; velocity_x_tx = 4'hF; velocity_y_tx = 4'd0; sign_y_tx = 1'b1;
        pulse(7'b0000100);
        check_val("ovr_pending", 32'(pending), 32'h04);
        check_val("ovr_inflight", 32'(message_data_out), 32'h300001);
        complete("ovr_ng");
        wait_frames(base + 2, "ovr_ball");
        check_val("ovr_ball_frame", 32'(frames[base+1]), 32'h1007E1);
        complete("ovr_ball");
        repeat (20) tick();
        check_val("ovr_count", 32'(frames.size()), 32'(base + 2));

`ifdef COMM_TX_RETRY_EN
        // No ack: original plus three retries, then drop
        base = frames.size();
        pulse(7'b0000001);
        wait_frames(base + 1, "rty_first");
        wait_idle("rty_drop");
        check_val("rty_pulses", 32'(frames.size() - base), 32'd4);
        check_val("rty_last_frame", 32'(frames[frames.size()-1]), 32'h600000);
        check_val("rty_link_lost", 32'(link_lost), 32'd1);
        check_val("rty_busy", 32'(busy), 32'd0);
        base = frames.size();
        pulse(7'b0100000);
        check_val("rty_ng_clears", 32'(link_lost), 32'd0);
        wait_frames(base + 1, "rty_ng");
        complete("rty_ng");

        // Ack arriving after the first retry
        base = frames.size();
        pulse(7'b0000010);
        wait_frames(base + 2, "late_retry");
        ack_current("late_ack");
        wait_idle("late_idle");
        repeat (60) tick();
        check_val("late_count", 32'(frames.size() - base), 32'd2);
        check_val("late_frame", 32'(frames[base+1]), 32'h500000);
        check_val("late_link_lost", 32'(link_lost), 32'd0);
`endif

        // Reset while in flight with BALL pending
        base = frames.size();
        pulse(7'b0001000);
        wait_frames(base + 1, "rstm_lost");
        check_val("rstm_lost_frame", 32'(frames[base]), 32'h700000);
        pulse(7'b0000100);
`ifdef COMM_TX_RETRY_EN
        wait_ready("rstm_ready");
        repeat (2) tick();
`endif
        check_val("rstm_pre_pending", 32'(pending), 32'h04);
        check_val("rstm_pre_busy", 32'(busy), 32'd1);
        #1 reset = 1'b1;
        #1;
        check_val("rstm_send", 32'(send_new_message), 32'd0);
        check_val("rstm_data", 32'(message_data_out), 32'd0);
        check_val("rstm_busy", 32'(busy), 32'd0);
        check_val("rstm_pending", 32'(pending), 32'd0);
        check_val("rstm_link_lost", 32'(link_lost), 32'd0);
        tick();
        reset = 1'b0;
        repeat (40) tick();
        check_val("rstm_no_send", 32'(frames.size()), 32'(base + 1));
        check_val("rstm_idle_busy", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
